// File: rtl/plab4_net_router_output_ctrl_if.sv
// Handshake bundle between the three input controllers, this output
// arbiter and the downstream channel of one router output port.
interface plab4_net_router_output_ctrl_if #(
   parameter int p_num_reqs = 3
);
   localparam int c_sel_nbits = (p_num_reqs > 1) ? $clog2(p_num_reqs) : 1;

   // Valid/ready rule: a message moves only in a cycle where out_val and
   // out_rdy are both high; grants is nonzero in exactly those cycles.
   logic [p_num_reqs-1:0]  reqs;
   logic [p_num_reqs-1:0]  grants;
   logic                   out_val;
   logic                   out_rdy;
   logic [c_sel_nbits-1:0] xbar_sel;

   modport master (
      input  reqs,
      input  out_rdy,
      output grants,
      output out_val,
      output xbar_sel
   );

   modport slave (
      output reqs,
      output out_rdy,
      input  grants,
      input  out_val,
      input  xbar_sel
   );
endinterface

// File: rtl/plab4_net_router_output_ctrl.sv
// Round-robin output arbiter: picks one requesting input, drives crossbar
// select and out_val, and holds a stalled winner until it transfers.
module plab4_net_router_output_ctrl #(
   parameter int                    p_num_reqs   = 3,
   parameter logic [p_num_reqs-1:0] p_prio_reset = 3'b001
) (
   input logic                            clk,
   input logic                            reset,
   plab4_net_router_output_ctrl_if.master bus
);
   localparam int c_sel_nbits = (p_num_reqs > 1) ? $clog2(p_num_reqs) : 1;

   logic [p_num_reqs-1:0]  prio_q, prio_d;
   logic                   lock_val_q, lock_val_d;
   logic [p_num_reqs-1:0]  lock_grant_q, lock_grant_d;

   logic [p_num_reqs-1:0]  arb_grant;
   logic [p_num_reqs-1:0]  winner;
   logic [c_sel_nbits-1:0] winner_idx;
   logic                   lock_hit;
   logic                   any_win;
   logic                   xfer;

   // Circular scan starting at the one-hot priority position.
   always_comb begin
      int  j;
      logic found;
      arb_grant = '0;
      found     = 1'b0;
      j         = 0;
      for (int i = 0; i < p_num_reqs; i++) begin
         for (int k = 0; k < p_num_reqs; k++) begin
            j = i + k;
            if (j >= p_num_reqs) j = j - p_num_reqs;
            if (prio_q[i] && !found && bus.reqs[j]) begin
               arb_grant[j] = 1'b1;
               found        = 1'b1;
            end
         end
      end
   end

   // A lock whose owner has dropped its request is ignored this cycle.
   always_comb begin
      lock_hit = lock_val_q && (|(lock_grant_q & bus.reqs));
      winner   = lock_hit ? lock_grant_q : arb_grant;
      any_win  = |winner;
   end

   always_comb begin
      winner_idx = '0;
      for (int i = 0; i < p_num_reqs; i++) begin
         if (winner[i]) winner_idx = c_sel_nbits'(i);
      end
   end

   always_comb begin
      xfer         = any_win && bus.out_rdy;
      prio_d       = prio_q;
      lock_val_d   = lock_val_q;
      lock_grant_d = lock_grant_q;
      if (xfer) begin
         prio_d     = {winner[p_num_reqs-2:0], winner[p_num_reqs-1]};
         lock_val_d = 1'b0;
      end else if (any_win) begin
         lock_val_d   = 1'b1;
         lock_grant_d = winner;
      end else begin
         lock_val_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prio_q       <= p_prio_reset;
         lock_val_q   <= 1'b0;
         lock_grant_q <= '0;
      end else begin
         prio_q       <= prio_d;
         lock_val_q   <= lock_val_d;
         lock_grant_q <= lock_grant_d;
      end
   end

   // Outputs are forced quiet while reset is held, whatever the inputs do.
   always_comb begin
      if (reset) begin
         bus.grants   = '0;
         bus.out_val  = 1'b0;
         bus.xbar_sel = '0;
      end else begin
         bus.grants   = winner & {p_num_reqs{bus.out_rdy}};
         bus.out_val  = any_win;
         bus.xbar_sel = winner_idx;
      end
   end
endmodule

// File: tb/tb_plab4_net_router_output_ctrl.sv
// Directed bench for the output arbiter: literal vectors from the test plan
// plus a per-cycle comparison against an index-based round-robin model.
`timescale 1ns/1ps
module tb_plab4_net_router_output_ctrl;
   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;
   logic check_en;

   plab4_net_router_output_ctrl_if #(.p_num_reqs(3)) bus ();

   plab4_net_router_output_ctrl #(.p_num_reqs(3), .p_prio_reset(3'b001)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // clock/reset block: period 20, posedge at 10 mod 20, negedge at 0 mod 20
   initial clk = 1'b0;
   always #10 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run still active at 200000 ns, required finish");
      $fatal(1, "watchdog");
   end

   // model: priority as an index, lock as an index (-1 = none)
   int m_prio;
   int m_lock;

   function automatic int m_winner(input logic [2:0] r, input int prio, input int lock);
      if (lock >= 0 && r[lock]) return lock;
      for (int k = 0; k < 3; k++) begin
         if (r[(prio + k) % 3]) return (prio + k) % 3;
      end
      return -1;
   endfunction

   always @(posedge clk or posedge reset) begin
      int w;
      if (reset) begin
         m_prio <= 0;
         m_lock <= -1;
      end else begin
         w = m_winner(bus.reqs, m_prio, m_lock);
         if (w >= 0 && bus.out_rdy) begin
            m_prio <= (w + 1) % 3;
            m_lock <= -1;
         end else if (w >= 0) begin
            m_lock <= w;
         end else begin
            m_lock <= -1;
         end
      end
   end

   // compare process: every cycle outside reset, 3 ns after the negedge
   always @(negedge clk) begin
      int         w;
      logic [2:0] eg;
      logic       ev;
      logic [1:0] es;
      #3;
      if (check_en && !reset) begin
         w  = m_winner(bus.reqs, m_prio, m_lock);
         ev = (w >= 0);
         es = (w >= 0) ? 2'(w) : 2'd0;
         eg = (w >= 0 && bus.out_rdy) ? 3'(1 << w) : 3'b000;
         vectors++;
         if (bus.grants !== eg || bus.out_val !== ev || bus.xbar_sel !== es) begin
            miscompares++;
            $display("FAIL model t=%0t reqs=%b rdy=%b: got grants=%b val=%b sel=%0d, want grants=%b val=%b sel=%0d",
                     $time, bus.reqs, bus.out_rdy, bus.grants, bus.out_val, bus.xbar_sel, eg, ev, es);
         end
      end
   end

   task automatic check_out(input string nm, input logic [2:0] eg, input logic ev, input logic [1:0] es);
      vectors++;
      if (bus.grants !== eg || bus.out_val !== ev || bus.xbar_sel !== es) begin
         miscompares++;
         $display("FAIL %s: got grants=%b val=%b sel=%0d, want grants=%b val=%b sel=%0d",
                  nm, bus.grants, bus.out_val, bus.xbar_sel, eg, ev, es);
      end
   endtask

   // driver: inputs change 1 ns after the negedge, literal check at +2 ns
   task automatic vec(input string nm, input logic [2:0] r, input logic rdy,
                      input logic [2:0] eg, input logic ev, input logic [1:0] es);
      @(negedge clk);
      #1;
      bus.reqs    = r;
      bus.out_rdy = rdy;
      #1;
      check_out(nm, eg, ev, es);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      reset       = 1'b1;
      bus.reqs    = 3'b111;
      bus.out_rdy = 1'b1;
      #1;
      check_out("reset_quiet", 3'b000, 1'b0, 2'd0);
      @(negedge clk);
      #1;
      reset       = 1'b0;
      bus.reqs    = 3'b000;
      bus.out_rdy = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      check_en    = 1'b0;
      reset       = 1'b1;
      bus.reqs    = 3'b000;
      bus.out_rdy = 1'b0;
      repeat (2) @(posedge clk);
      do_reset();
      check_en = 1'b1;

      // 1: full rotation
      vec("rr0", 3'b111, 1'b1, 3'b001, 1'b1, 2'd0);
      vec("rr1", 3'b111, 1'b1, 3'b010, 1'b1, 2'd1);
      vec("rr2", 3'b111, 1'b1, 3'b100, 1'b1, 2'd2);
      vec("rr3", 3'b111, 1'b1, 3'b001, 1'b1, 2'd0);

      // 2: idle leaves priority at its reset value
      do_reset();
      vec("idle", 3'b000, 1'b1, 3'b000, 1'b0, 2'd0);
      vec("after_idle", 3'b110, 1'b1, 3'b010, 1'b1, 2'd1);

      // 3: stall hold, then release and rotate
      vec("stall0", 3'b001, 1'b0, 3'b000, 1'b1, 2'd0);
      vec("stall1", 3'b001, 1'b0, 3'b000, 1'b1, 2'd0);
      vec("stall2", 3'b001, 1'b0, 3'b000, 1'b1, 2'd0);
      vec("stall_hold", 3'b101, 1'b0, 3'b000, 1'b1, 2'd0);
      vec("stall_xfer", 3'b101, 1'b1, 3'b001, 1'b1, 2'd0);
      vec("post_stall", 3'b101, 1'b1, 3'b100, 1'b1, 2'd2);

      // 4: single requester every cycle
      for (int i = 0; i < 5; i++) vec("single", 3'b100, 1'b1, 3'b100, 1'b1, 2'd2);

      // 5: locked input drops its request
      vec("lock1", 3'b010, 1'b0, 3'b000, 1'b1, 2'd1);
      vec("lock_release", 3'b001, 1'b0, 3'b000, 1'b1, 2'd0);
      vec("relock_xfer", 3'b011, 1'b1, 3'b001, 1'b1, 2'd0);

      // 6: asynchronous reset in the middle of a stall
      vec("lock2", 3'b100, 1'b0, 3'b000, 1'b1, 2'd2);
      vec("lock2_hold", 3'b111, 1'b0, 3'b000, 1'b1, 2'd2);
      #3;
      reset = 1'b1;
      #1;
      check_out("async_reset", 3'b000, 1'b0, 2'd0);
      @(negedge clk);
      #1;
      reset       = 1'b0;
      bus.reqs    = 3'b111;
      bus.out_rdy = 1'b1;
      #1;
      check_out("post_reset", 3'b001, 1'b1, 2'd0);
      vec("post_reset2", 3'b111, 1'b1, 3'b010, 1'b1, 2'd1);

      @(negedge clk);
      #5;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
